iob_cache_mp_front_end: RTL and testbench

IOB_CACHE_MP_FRONT_END -- requirements
Module: iob_cache_mp_front_end

---
 rtl/iob_cache_mp_front_end_pkg.sv | 16 +
 rtl/iob_cache_mp_front_end_arbiter.sv | 47 ++++
 rtl/iob_cache_mp_front_end.sv | 126 ++++++++++++
 tb/tb_iob_cache_mp_front_end.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_mp_front_end_pkg.sv
// Shared configuration for the multi-port cache front end: FSM state
// encodings, default port count and grant-index width derivation.
package iob_cache_mp_front_end_pkg;

  localparam int N_PORTS_DEFAULT = 4;

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_ISSUE  = 2'd1;
  localparam logic [1:0] STATE_WAIT_R = 2'd2;

  // Grant index width: at least one bit even for tiny port counts.
  function automatic int calc_n_ports_w(input int n_ports);
    return (n_ports > 2) ? $clog2(n_ports) : 1;
  endfunction

endpackage

// File: rtl/iob_cache_mp_front_end_arbiter.sv
// Request arbiter for the multi-port cache front end.
// Default build: round-robin, search starts one past last_grant and wraps.
// With IOB_CACHE_MP_FIXED_PRIO_EN defined: fixed priority, lowest index wins
// and last_grant is ignored.
module iob_cache_rr_arbiter #(
  parameter int N_PORTS   = 4,
  parameter int N_PORTS_W = 2
) (
  input  logic [N_PORTS-1:0]   req,
  input  logic [N_PORTS_W-1:0] last_grant,
  output logic [N_PORTS_W-1:0] winner,
  output logic                 any_req
);

  assign any_req = |req;

`ifdef IOB_CACHE_MP_FIXED_PRIO_EN
  logic [N_PORTS_W-1:0] unused_last_grant;
  assign unused_last_grant = last_grant;

  // Scan from the top down so the lowest requesting index is written last.
  always_comb begin
    winner = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (req[i]) winner = N_PORTS_W'(i);
    end
  end
`else
  int   idx;
  logic found;

  // Walk the ports starting just after the previous winner; first hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = (int'(last_grant) + 1 + i) % N_PORTS;
      if (!found && req[idx]) begin
        winner = N_PORTS_W'(idx);
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/iob_cache_mp_front_end.sv
// Multi-port IOb front end: arbitrates N_PORTS native slave ports onto a
// single cache-core master port, one transaction outstanding at a time.
// Optional macro IOB_CACHE_MP_FIXED_PRIO_EN selects fixed-priority arbitration
// instead of the default round-robin.
module iob_cache_mp_front_end
  import iob_cache_mp_front_end_pkg::*;
#(
  parameter  int N_PORTS   = N_PORTS_DEFAULT,
  parameter  int ADDR_W    = 30,
  parameter  int DATA_W    = 32,
  localparam int N_PORTS_W = calc_n_ports_w(N_PORTS)
) (
  input  logic                        clk_i,
  input  logic                        cke_i,
  input  logic                        arst_i,
  input  logic [N_PORTS-1:0]          iob_valid_i,
  input  logic [N_PORTS*ADDR_W-1:0]   iob_addr_i,
  input  logic [N_PORTS*DATA_W-1:0]   iob_wdata_i,
  input  logic [N_PORTS*DATA_W/8-1:0] iob_wstrb_i,
  output logic [N_PORTS-1:0]          iob_ready_o,
  output logic [N_PORTS-1:0]          iob_rvalid_o,
  output logic [N_PORTS*DATA_W-1:0]   iob_rdata_o,
  output logic                        cache_valid_o,
  output logic [ADDR_W-1:0]           cache_addr_o,
  output logic [DATA_W-1:0]           cache_wdata_o,
  output logic [DATA_W/8-1:0]         cache_wstrb_o,
  input  logic                        cache_ready_i,
  input  logic                        cache_rvalid_i,
  input  logic [DATA_W-1:0]           cache_rdata_i,
  output logic [N_PORTS_W-1:0]        grant_o
);

  localparam int STRB_W = DATA_W / 8;

  logic [1:0]           state;
  logic [N_PORTS_W-1:0] grant;
  logic [N_PORTS_W-1:0] last_grant;
  logic [N_PORTS_W-1:0] winner;
  logic                 any_req;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [STRB_W-1:0]    sel_wstrb;
  logic                 issue;
  logic                 is_write;
  logic                 ack;
  logic                 rsp;

  iob_cache_rr_arbiter #(
    .N_PORTS   (N_PORTS),
    .N_PORTS_W (N_PORTS_W)
  ) arbiter (
    .req        (iob_valid_i),
    .last_grant (last_grant),
    .winner     (winner),
    .any_req    (any_req)
  );

  // Route the granted port's live request fields onto the shared path.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (grant == N_PORTS_W'(p)) begin
        sel_addr  = iob_addr_i[p*ADDR_W +: ADDR_W];
        sel_wdata = iob_wdata_i[p*DATA_W +: DATA_W];
        sel_wstrb = iob_wstrb_i[p*STRB_W +: STRB_W];
      end
    end
  end

  assign issue    = (state == STATE_ISSUE);
  assign is_write = |sel_wstrb;
  assign ack      = issue && cache_ready_i;
  assign rsp      = cache_rvalid_i && ((ack && !is_write) || (state == STATE_WAIT_R));

  // Master side is quiet outside ISSUE so idle/reset outputs read as zero.
  assign cache_valid_o = issue;
  assign cache_addr_o  = issue ? sel_addr  : '0;
  assign cache_wdata_o = issue ? sel_wdata : '0;
  assign cache_wstrb_o = issue ? sel_wstrb : '0;

  // Read data is broadcast; only the granted port's rvalid qualifies it.
  assign iob_rdata_o = {N_PORTS{cache_rdata_i}};
  assign grant_o     = grant;

  // Steer the cache handshake back to the granted port only.
  always_comb begin
    iob_ready_o  = '0;
    iob_rvalid_o = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      iob_ready_o[p]  = ack && (grant == N_PORTS_W'(p));
      iob_rvalid_o[p] = rsp && (grant == N_PORTS_W'(p));
    end
  end

  // Transaction FSM; reset drops any in-flight read and primes port 0 to win first.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state      <= STATE_IDLE;
      grant      <= '0;
      last_grant <= N_PORTS_W'(N_PORTS - 1);
    end else if (cke_i) begin
      case (state)
        STATE_IDLE: begin
          if (any_req) begin
            grant      <= winner;
            last_grant <= winner;
            state      <= STATE_ISSUE;
          end
        end
        STATE_ISSUE: begin
          if (cache_ready_i) begin
            if (is_write || cache_rvalid_i) state <= STATE_IDLE;
            else                            state <= STATE_WAIT_R;
          end
        end
        STATE_WAIT_R: begin
          if (cache_rvalid_i) state <= STATE_IDLE;
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_cache_mp_front_end.sv
// Scoreboard bench for iob_cache_mp_front_end. Directed stimulus pushes the
// expected port-side handshakes; a negedge monitor pops and compares them.
// Build with IOB_CACHE_MP_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_iob_cache_mp_front_end;

  localparam int N_PORTS = 4;
  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = DATA_W / 8;
  localparam int GW      = 2;

  logic                        clk_i = 1'b0;
  logic                        cke_i;
  logic                        arst_i;
  logic [N_PORTS-1:0]          iob_valid_i;
  logic [N_PORTS*ADDR_W-1:0]   iob_addr_i;
  logic [N_PORTS*DATA_W-1:0]   iob_wdata_i;
  logic [N_PORTS*STRB_W-1:0]   iob_wstrb_i;
  logic [N_PORTS-1:0]          iob_ready_o;
  logic [N_PORTS-1:0]          iob_rvalid_o;
  logic [N_PORTS*DATA_W-1:0]   iob_rdata_o;
  logic                        cache_valid_o;
  logic [ADDR_W-1:0]           cache_addr_o;
  logic [DATA_W-1:0]           cache_wdata_o;
  logic [STRB_W-1:0]           cache_wstrb_o;
  logic                        cache_ready_i;
  logic                        cache_rvalid_i;
  logic [DATA_W-1:0]           cache_rdata_i;
  logic [GW-1:0]               grant_o;

  typedef struct {
    logic [N_PORTS-1:0] ready;
    logic [N_PORTS-1:0] rvalid;
    logic [DATA_W-1:0]  rdata;
  } hs_t;

  hs_t exp_q[$];
  hs_t mon_e;
  int  n_checks = 0;
  int  n_fails  = 0;
  int  exp_g;

  iob_cache_mp_front_end #(
    .N_PORTS (N_PORTS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk_i          (clk_i),
    .cke_i          (cke_i),
    .arst_i         (arst_i),
    .iob_valid_i    (iob_valid_i),
    .iob_addr_i     (iob_addr_i),
    .iob_wdata_i    (iob_wdata_i),
    .iob_wstrb_i    (iob_wstrb_i),
    .iob_ready_o    (iob_ready_o),
    .iob_rvalid_o   (iob_rvalid_o),
    .iob_rdata_o    (iob_rdata_o),
    .cache_valid_o  (cache_valid_o),
    .cache_addr_o   (cache_addr_o),
    .cache_wdata_o  (cache_wdata_o),
    .cache_wstrb_o  (cache_wstrb_o),
    .cache_ready_i  (cache_ready_i),
    .cache_rvalid_i (cache_rvalid_i),
    .cache_rdata_i  (cache_rdata_i),
    .grant_o        (grant_o)
  );

  // Free-running system clock.
  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input int p, input logic v, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    iob_valid_i[p]                 = v;
    iob_addr_i[p*ADDR_W +: ADDR_W] = a;
    iob_wdata_i[p*DATA_W +: DATA_W] = d;
    iob_wstrb_i[p*STRB_W +: STRB_W] = s;
  endtask

  task automatic expect_hs(input logic [N_PORTS-1:0] r, input logic [N_PORTS-1:0] v,
                           input logic [DATA_W-1:0] d);
    exp_q.push_back('{ready: r, rvalid: v, rdata: d});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_reset();
    arst_i = 1'b1;
    #1;
    check_output("rst_grant", grant_o, 0);
    check_output("rst_cache_valid", cache_valid_o, 0);
    tick();
    arst_i = 1'b0;
  endtask

  // Monitor: every port-side handshake must match the next scoreboard entry.
  always @(negedge clk_i) begin
    if ((iob_ready_o | iob_rvalid_o) != '0) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_handshake", {iob_ready_o, iob_rvalid_o}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("iob_ready", iob_ready_o, mon_e.ready);
        check_output("iob_rvalid", iob_rvalid_o, mon_e.rvalid);
        if (mon_e.rvalid != '0)
          check_output("iob_rdata", iob_rdata_o, {N_PORTS{mon_e.rdata}});
      end
    end
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cke_i          = 1'b1;
    arst_i         = 1'b1;
    iob_valid_i    = '0;
    iob_addr_i     = '0;
    iob_wdata_i    = '0;
    iob_wstrb_i    = '0;
    cache_ready_i  = 1'b0;
    cache_rvalid_i = 1'b0;
    cache_rdata_i  = '0;
    #1;
    check_output("rst_grant", grant_o, 0);
    check_output("rst_cache_valid", cache_valid_o, 0);
    check_output("rst_cache_addr", cache_addr_o, 0);
    check_output("rst_cache_wstrb", cache_wstrb_o, 0);
    check_output("rst_ready", iob_ready_o, 0);
    check_output("rst_rvalid", iob_rvalid_o, 0);
    tick();
    tick();
    arst_i = 1'b0;

    // Port 0 read, ready after one ISSUE cycle, rvalid two cycles later.
    apply_stimulus(0, 1'b1, 30'h10, 32'h0, 4'h0);
    tick();
    check_output("t1_grant", grant_o, 0);
    check_output("t1_cache_valid", cache_valid_o, 1);
    check_output("t1_cache_addr", cache_addr_o, 30'h10);
    check_output("t1_cache_wstrb", cache_wstrb_o, 0);
    cache_ready_i = 1'b1;
    expect_hs(4'b0001, 4'b0000, 32'h0);
    tick();
    apply_stimulus(0, 1'b0, 30'h0, 32'h0, 4'h0);
    cache_ready_i = 1'b0;
    check_output("t1_wait_valid", cache_valid_o, 0);
    tick();
    cache_rvalid_i = 1'b1;
    cache_rdata_i  = 32'hDEADBEEF;
    expect_hs(4'b0000, 4'b0001, 32'hDEADBEEF);
    tick();
    cache_rvalid_i = 1'b0;
    check_output("t1_idle_valid", cache_valid_o, 0);

    // All four ports writing continuously: grant order after reset.
    pulse_reset();
    for (int p = 0; p < N_PORTS; p++)
      apply_stimulus(p, 1'b1, ADDR_W'(32'h100 + p), 32'hA0 + p, 4'hF);
    cache_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
`ifdef IOB_CACHE_MP_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = k % N_PORTS;
`endif
      check_output("t2_grant", grant_o, exp_g);
      check_output("t2_cache_addr", cache_addr_o, 32'h100 + exp_g);
      check_output("t2_cache_wdata", cache_wdata_o, 32'hA0 + exp_g);
      expect_hs(N_PORTS'(1) << exp_g, 4'b0000, 32'h0);
      tick();
    end
    for (int p = 0; p < N_PORTS; p++)
      apply_stimulus(p, 1'b0, 30'h0, 32'h0, 4'h0);
    cache_ready_i = 1'b0;

    // Port 2 write stalled five cycles by the cache; stray rvalid ignored.
    apply_stimulus(2, 1'b1, 30'h2A0, 32'h55AA0202, 4'hF);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_output("t3_valid_held", cache_valid_o, 1);
      check_output("t3_grant", grant_o, 2);
      cache_rvalid_i = (i == 2);
      tick();
    end
    cache_rvalid_i = 1'b0;
    check_output("t3_cache_wdata", cache_wdata_o, 32'h55AA0202);
    check_output("t3_cache_wstrb", cache_wstrb_o, 4'hF);
    cache_ready_i = 1'b1;
    expect_hs(4'b0100, 4'b0000, 32'h0);
    tick();
    apply_stimulus(2, 1'b0, 30'h0, 32'h0, 4'h0);
    cache_ready_i = 1'b0;
    check_output("t3_idle_valid", cache_valid_o, 0);

    // Port 1 read: stray rvalid without ready, then ready+rvalid together.
    apply_stimulus(1, 1'b1, 30'h3C, 32'h0, 4'h0);
    tick();
    check_output("t4_grant", grant_o, 1);
    cache_rvalid_i = 1'b1;
    cache_rdata_i  = 32'hBAD0BAD0;
    tick();
    check_output("t4_still_issue", cache_valid_o, 1);
    cache_ready_i = 1'b1;
    cache_rdata_i = 32'h12345678;
    expect_hs(4'b0010, 4'b0010, 32'h12345678);
    tick();
    apply_stimulus(1, 1'b0, 30'h0, 32'h0, 4'h0);
    cache_ready_i = 1'b0;
    check_output("t4_idle_valid", cache_valid_o, 0);
    tick();
    cache_rvalid_i = 1'b0;

    // Reset during WAIT_R drops the read; port 0 wins next.
    apply_stimulus(3, 1'b1, 30'h77, 32'h0, 4'h0);
    tick();
    check_output("t5_grant3", grant_o, 3);
    cache_ready_i = 1'b1;
    expect_hs(4'b1000, 4'b0000, 32'h0);
    tick();
    apply_stimulus(3, 1'b0, 30'h0, 32'h0, 4'h0);
    cache_ready_i = 1'b0;
    check_output("t5_wait_valid", cache_valid_o, 0);
    pulse_reset();
    cache_rvalid_i = 1'b1;
    cache_rdata_i  = 32'hFFFF0000;
    tick();
    cache_rvalid_i = 1'b0;
    apply_stimulus(0, 1'b1, 30'h5, 32'h0, 4'h0);
    apply_stimulus(2, 1'b1, 30'h9, 32'h0, 4'h0);
    tick();
    check_output("t5_grant0", grant_o, 0);
    check_output("t5_cache_addr", cache_addr_o, 30'h5);
    cache_ready_i = 1'b1;
    expect_hs(4'b0001, 4'b0000, 32'h0);
    tick();
    apply_stimulus(0, 1'b0, 30'h0, 32'h0, 4'h0);
    apply_stimulus(2, 1'b0, 30'h0, 32'h0, 4'h0);
    cache_ready_i  = 1'b0;
    cache_rvalid_i = 1'b1;
    cache_rdata_i  = 32'hCAFEF00D;
    expect_hs(4'b0000, 4'b0001, 32'hCAFEF00D);
    tick();
    cache_rvalid_i = 1'b0;

    // Clock enable low freezes IDLE and ISSUE; operation then resumes.
    apply_stimulus(1, 1'b1, 30'h1F0, 32'h0BADCAFE, 4'h3);
    cke_i = 1'b0;
    tick();
    check_output("t6_idle_frozen", cache_valid_o, 0);
    cke_i = 1'b1;
    tick();
    check_output("t6_grant", grant_o, 1);
    cke_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("t6_frozen_valid", cache_valid_o, 1);
      check_output("t6_frozen_grant", grant_o, 1);
    end
    cke_i         = 1'b1;
    cache_ready_i = 1'b1;
    check_output("t6_cache_wstrb", cache_wstrb_o, 4'h3);
    expect_hs(4'b0010, 4'b0000, 32'h0);
    tick();
    apply_stimulus(1, 1'b0, 30'h0, 32'h0, 4'h0);
    check_output("t6_idle_valid", cache_valid_o, 0);
    apply_stimulus(0, 1'b1, 30'h40, 32'h1, 4'hF);
    apply_stimulus(2, 1'b1, 30'h42, 32'h2, 4'hF);
    tick();
`ifdef IOB_CACHE_MP_FIXED_PRIO_EN
    exp_g = 0;
`else
    exp_g = 2;
`endif
    check_output("t6_next_grant", grant_o, exp_g);
    expect_hs(N_PORTS'(1) << exp_g, 4'b0000, 32'h0);
    tick();
    apply_stimulus(0, 1'b0, 30'h0, 32'h0, 4'h0);
    apply_stimulus(2, 1'b0, 30'h0, 32'h0, 4'h0);
    cache_ready_i = 1'b0;
    tick();
    tick();

    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
